// File: rtl/cmd_host_mstr.sv
// Command host master: sends CMD_BYTES-byte command frames over an 8N1 UART
// and collects response bytes on the return line. It keeps response
// flags and a byte counter, and a watchdog that fires when no response starts.
module cmd_host_mstr #(
  parameter int CMD_BYTES = 3,
  parameter int BAUD_DIV  = 2604,
  parameter int TMO_CYC   = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*CMD_BYTES-1:0] cmd,
  input  logic                   send_cmd,
  output logic                   busy,
  output logic                   cmd_sent,
  output logic                   TX,
  input  logic                   RX,
  output logic [7:0]             resp,
  output logic                   resp_rdy,
  input  logic                   clr_resp_rdy,
  output logic [15:0]            resp_cnt,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int FRAME_W = 8 * CMD_BYTES;
  localparam int BAUD_W  = $clog2(BAUD_DIV);
  localparam int BYTE_W  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(CMD_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uartState_e;

  // ---------------------------------------------------------------------
  // Transmit side
  // ---------------------------------------------------------------------
  uartState_e          txState_q, txState_d;
  logic [BAUD_W-1:0]   txBaud_q, txBaud_d;
  logic [2:0]          txBit_q, txBit_d;
  logic [BYTE_W-1:0]   txByte_q, txByte_d;
  logic [FRAME_W-1:0]  txShift_q, txShift_d;
  logic                cmdSent_q, cmdSent_d;
  logic [7:0]          txCur;
  logic                accept;

  // A request is only taken while the transmitter is idle; this includes
  // the cmd_sent cycle, so frames can be chained without losing a request.
  assign accept = send_cmd && (txState_q == ST_IDLE);
  assign txCur  = txShift_q[FRAME_W-1 -: 8];

  // Transmit FSM next state: walks start/data/stop per byte, oldest byte at the top.
  always_comb begin
    txState_d = txState_q;
    txBaud_d  = txBaud_q;
    txBit_d   = txBit_q;
    txByte_d  = txByte_q;
    txShift_d = txShift_q;
    cmdSent_d = 1'b0;
    case (txState_q)
      ST_IDLE: begin
        if (send_cmd) begin
          txShift_d = cmd;
          txBaud_d  = '0;
          txBit_d   = '0;
          txByte_d  = '0;
          txState_d = ST_START;
        end
      end
      ST_START: begin
        if (txBaud_q == BAUD_LAST) begin
          txBaud_d  = '0;
          txBit_d   = '0;
          txState_d = ST_DATA;
        end else begin
          txBaud_d = txBaud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (txBaud_q == BAUD_LAST) begin
          txBaud_d = '0;
          if (txBit_q == 3'd7) begin
            txState_d = ST_STOP;
          end else begin
            txBit_d = txBit_q + 1'b1;
          end
        end else begin
          txBaud_d = txBaud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (txBaud_q == BAUD_LAST) begin
          txBaud_d = '0;
          if (txByte_q == BYTE_LAST) begin
            txState_d = ST_IDLE;
            cmdSent_d = 1'b1;
          end else begin
            txByte_d  = txByte_q + 1'b1;
            txShift_d = txShift_q << 8;
            txState_d = ST_START;
          end
        end else begin
          txBaud_d = txBaud_q + 1'b1;
        end
      end
      default: txState_d = ST_IDLE;
    endcase
  end

  // Transmit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState_q <= ST_IDLE;
      txBaud_q  <= '0;
      txBit_q   <= '0;
      txByte_q  <= '0;
      txShift_q <= '0;
      cmdSent_q <= 1'b0;
    end else begin
      txState_q <= txState_d;
      txBaud_q  <= txBaud_d;
      txBit_q   <= txBit_d;
      txByte_q  <= txByte_d;
      txShift_q <= txShift_d;
      cmdSent_q <= cmdSent_d;
    end
  end

  // Serial line level, decoded from state so reset drives it high immediately.
  always_comb begin
    TX = 1'b1;
    case (txState_q)
      ST_START: TX = 1'b0;
      ST_DATA:  TX = txCur[txBit_q];
      default:  TX = 1'b1;
    endcase
  end

  assign busy     = (txState_q != ST_IDLE);
  assign cmd_sent = cmdSent_q;

  // ---------------------------------------------------------------------
  // Receive side
  // ---------------------------------------------------------------------
  uartState_e          rxState_q, rxState_d;
  logic [BAUD_W-1:0]   rxBaud_q, rxBaud_d;
  logic [2:0]          rxBit_q, rxBit_d;
  logic [7:0]          rxShift_q, rxShift_d;
  logic                rxMeta_q, rxSync_q;
  logic                byteDone;
  logic                startOk;

  // Two-flop synchroniser for the asynchronous RX line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= RX;
      rxSync_q <= rxMeta_q;
    end
  end

  // Receive FSM next state: confirm start at half a bit, then sample mid-bit.
  always_comb begin
    rxState_d = rxState_q;
    rxBaud_d  = rxBaud_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    byteDone  = 1'b0;
    startOk   = 1'b0;
    case (rxState_q)
      ST_IDLE: begin
        if (!rxSync_q) begin
          rxBaud_d  = '0;
          rxState_d = ST_START;
        end
      end
      ST_START: begin
        if (rxBaud_q == HALF_LAST) begin
          rxBaud_d = '0;
          if (!rxSync_q) begin
            startOk   = 1'b1;
            rxBit_d   = '0;
            rxState_d = ST_DATA;
          end else begin
            rxState_d = ST_IDLE;
          end
        end else begin
          rxBaud_d = rxBaud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rxBaud_q == BAUD_LAST) begin
          rxBaud_d  = '0;
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          if (rxBit_q == 3'd7) begin
            rxState_d = ST_STOP;
          end else begin
            rxBit_d = rxBit_q + 1'b1;
          end
        end else begin
          rxBaud_d = rxBaud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rxBaud_q == BAUD_LAST) begin
          rxBaud_d  = '0;
          rxState_d = ST_IDLE;
          byteDone  = rxSync_q;
        end else begin
          rxBaud_d = rxBaud_q + 1'b1;
        end
      end
      default: rxState_d = ST_IDLE;
    endcase
  end

  // Receive FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState_q <= ST_IDLE;
      rxBaud_q  <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
    end else begin
      rxState_q <= rxState_d;
      rxBaud_q  <= rxBaud_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
    end
  end

  // ---------------------------------------------------------------------
  // Response register, flags and byte counter
  // ---------------------------------------------------------------------
  logic [7:0]  resp_q, resp_d;
  logic        respRdy_q, respRdy_d;
  logic [15:0] respCnt_q, respCnt_d;
  logic        overrun_q, overrun_d;

  // A completed byte always wins over a clear or a counter restart.
  always_comb begin
    resp_d    = resp_q;
    respRdy_d = respRdy_q;
    respCnt_d = respCnt_q;
    overrun_d = overrun_q;
    if (byteDone) begin
      resp_d = rxShift_q;
    end
    if (byteDone) begin
      respRdy_d = 1'b1;
    end else if (clr_resp_rdy) begin
      respRdy_d = 1'b0;
    end
    if (accept) begin
      respCnt_d = byteDone ? 16'd1 : 16'd0;
    end else if (byteDone && (respCnt_q != 16'hFFFF)) begin
      respCnt_d = respCnt_q + 16'd1;
    end
    if (byteDone && respRdy_q && !clr_resp_rdy) begin
      overrun_d = 1'b1;
    end else if (accept) begin
      overrun_d = 1'b0;
    end
  end

  // Response state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q    <= 8'h00;
      respRdy_q <= 1'b0;
      respCnt_q <= 16'd0;
      overrun_q <= 1'b0;
    end else begin
      resp_q    <= resp_d;
      respRdy_q <= respRdy_d;
      respCnt_q <= respCnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = respRdy_q;
  assign resp_cnt = respCnt_q;
  assign overrun  = overrun_q;

  // ---------------------------------------------------------------------
  // Response timeout watchdog
  // ---------------------------------------------------------------------
  logic             tmoAct_q, tmoAct_d;
  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
  logic             tmoPulse_q, tmoPulse_d;

  // Armed in the cmd_sent cycle so the pulse lands exactly TMO_CYC later.
  always_comb begin
    tmoAct_d   = tmoAct_q;
    tmoCnt_d   = tmoCnt_q;
    tmoPulse_d = 1'b0;
    if (cmdSent_q) begin
      tmoAct_d = 1'b1;
      tmoCnt_d = TMO_W'(1);
    end else if (tmoAct_q) begin
      if (startOk) begin
        tmoAct_d = 1'b0;
      end else if (tmoCnt_q >= TMO_LAST) begin
        tmoPulse_d = 1'b1;
        tmoAct_d   = 1'b0;
      end else begin
        tmoCnt_d = tmoCnt_q + 1'b1;
      end
    end
  end

  // Watchdog state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmoAct_q   <= 1'b0;
      tmoCnt_q   <= '0;
      tmoPulse_q <= 1'b0;
    end else begin
      tmoAct_q   <= tmoAct_d;
      tmoCnt_q   <= tmoCnt_d;
      tmoPulse_q <= tmoPulse_d;
    end
  end

  assign timeout = tmoPulse_q;

endmodule
